image_mem_sequencer: RTL and testbench

IMAGE_MEM_SEQUENCER -- requirements
Module: image_mem_sequencer

---
 rtl/image_mem_sequencer.sv | 118 +++++++++++
 tb/tb_image_mem_sequencer.sv | 145 ++++++++++++++
 2 files changed

// File: rtl/image_mem_sequencer.sv
// image_mem_sequencer: arbitrates draw writes and sweeps the image memory to stream pixels; IMG_CLEAR_EN adds a zeroing sweep.
module image_mem_sequencer #(
  parameter int GRID_SIZE = 28,
  parameter int NUM_PIX = 784,
  parameter int ADDR_W = 16,
  parameter int DATA_W = 32
) (
  input  logic              CLOCK_50,
  input  logic              reset,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              infer_start,
  input  logic              clear_start,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_we,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  output logic [9:0]        pix_index,
  output logic              busy,
  output logic              done
);
  localparam int npix = (NUM_PIX > 0) ? NUM_PIX : GRID_SIZE * GRID_SIZE;
  localparam logic [ADDR_W-1:0] last = ADDR_W'(npix - 1);
`ifdef IMG_CLEAR_EN
  typedef enum logic [1:0] {IDLE, READ, CLEAR} state_t;
`else
  typedef enum logic [1:0] {IDLE, READ} state_t;
  logic unused_clear;
  assign unused_clear = clear_start;
`endif
  state_t state, state_n;
  logic [ADDR_W-1:0] addr_n;
  logic [DATA_W-1:0] wdata_n, pd_n;
  logic [9:0] pi_n;
  logic we_n, pv_n, done_n;
  assign busy = state != IDLE;
  always_ff @(posedge CLOCK_50 or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      mem_addr <= '0;
      mem_wdata <= '0;
      mem_we <= 1'b0;
      pix_valid <= 1'b0;
      pix_data <= '0;
      pix_index <= '0;
      done <= 1'b0;
    end else begin
      state <= state_n;
      mem_addr <= addr_n;
      mem_wdata <= wdata_n;
      mem_we <= we_n;
      pix_valid <= pv_n;
      pix_data <= pd_n;
      pix_index <= pi_n;
      done <= done_n;
    end
  end
  // READ holds one extra drain cycle after the last address so the final word is presented with done
  always_comb begin
    state_n = state;
    addr_n = mem_addr;
    wdata_n = mem_wdata;
    pd_n = pix_data;
    pi_n = pix_index;
    we_n = 1'b0;
    pv_n = 1'b0;
    done_n = 1'b0;
    wr_gnt = 1'b0;
    case (state)
      IDLE:
        if (infer_start) begin
          state_n = READ;
          addr_n = '0;
        end
`ifdef IMG_CLEAR_EN
        else if (clear_start) begin
          state_n = CLEAR;
          addr_n = '0;
          wdata_n = '0;
          we_n = 1'b1;
          done_n = last == '0;
        end
`endif
        else if (wr_req) begin
          wr_gnt = 1'b1;
          if (wr_addr <= last) begin
            we_n = 1'b1;
            addr_n = wr_addr;
            wdata_n = wr_data;
          end
        end
      READ:
        if (done) state_n = IDLE;
        else begin
          pv_n = 1'b1;
          pd_n = mem_rdata;
          pi_n = mem_addr[9:0];
          done_n = mem_addr == last;
          addr_n = done_n ? mem_addr : mem_addr + 1'b1;
        end
`ifdef IMG_CLEAR_EN
      CLEAR:
        if (done) state_n = IDLE;
        else begin
          addr_n = mem_addr + 1'b1;
          wdata_n = '0;
          we_n = 1'b1;
          done_n = addr_n == last;
        end
`endif
      default: state_n = IDLE;
    endcase
  end
endmodule

// File: tb/tb_image_mem_sequencer.sv
// tb_image_mem_sequencer: scoreboard bench with a frame-level reference model for image_mem_sequencer.
module tb_image_mem_sequencer;
  localparam int N = 784;
`ifdef IMG_CLEAR_EN
  localparam bit clr_en = 1'b1;
`else
  localparam bit clr_en = 1'b0;
`endif
  typedef struct {int c; logic [15:0] a; logic [31:0] d;} ev_t;
  logic CLOCK_50 = 0, reset = 0, wr_req = 0, infer_start = 0, clear_start = 0;
  logic [15:0] wr_addr = 0, mem_addr;
  logic [31:0] wr_data = 0, mem_wdata, mem_rdata, pix_data;
  logic wr_gnt, mem_we, pix_valid, busy, done;
  logic [9:0] pix_index;
  logic [31:0] mem [0:1023];
  logic [31:0] ref_mem [0:N-1];
  ev_t wr_q[$], pix_q[$];
  int done_q[$];
  int cyc = 0, free_at = 0, n_cmp = 0, n_bad = 0;
  image_mem_sequencer dut (
    .CLOCK_50(CLOCK_50), .reset(reset), .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_gnt(wr_gnt), .infer_start(infer_start), .clear_start(clear_start), .mem_addr(mem_addr),
    .mem_wdata(mem_wdata), .mem_we(mem_we), .mem_rdata(mem_rdata), .pix_valid(pix_valid),
    .pix_data(pix_data), .pix_index(pix_index), .busy(busy), .done(done)
  );
  always #5 CLOCK_50 = ~CLOCK_50;
  always @(posedge CLOCK_50) cyc <= cyc + 1;
  assign mem_rdata = mem[mem_addr[9:0]];
  always @(posedge CLOCK_50) if (mem_we) mem[mem_addr[9:0]] <= mem_wdata;
  task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask
  // Inputs change 1ns after a rising edge; the reference model decides acceptance from the frame schedule
  task automatic drive(input bit inf, input bit clr, input bit req, input logic [15:0] a,
                       input logic [31:0] d, output bit g);
    bit idle, ce;
    infer_start = inf; clear_start = clr; wr_req = req; wr_addr = a; wr_data = d;
    #3;
    idle = cyc >= free_at;
    ce = clr_en && clr;
    g = idle && req && !inf && !ce;
    chk("busy", busy, !idle);
    chk("wr_gnt", wr_gnt, g);
    if (idle && inf) begin
      for (int k = 0; k < N; k++) pix_q.push_back('{cyc + 2 + k, 16'(k), ref_mem[k]});
      done_q.push_back(cyc + N + 1);
      free_at = cyc + N + 2;
    end else if (idle && ce) begin
      for (int k = 0; k < N; k++) begin
        wr_q.push_back('{cyc + 1 + k, 16'(k), 32'd0});
        ref_mem[k] = 0;
      end
      done_q.push_back(cyc + N);
      free_at = cyc + N + 1;
    end else if (g && int'(a) < N) begin
      wr_q.push_back('{cyc + 1, a, d});
      ref_mem[a] = d;
    end
    @(posedge CLOCK_50); #1;
    infer_start = 0; clear_start = 0; wr_req = 0;
  endtask
  task automatic idle_cycles(input int n);
    bit g;
    for (int i = 0; i < n; i++) drive(0, 0, 0, 0, 0, g);
  endtask
  always @(negedge CLOCK_50) begin
    ev_t e;
    int dc;
    if (!reset) begin
      if (mem_we) begin
        if (wr_q.size() == 0) chk("spurious_mem_we", mem_we, 0);
        else begin
          e = wr_q.pop_front();
          chk("mem_write", {cyc, mem_addr, mem_wdata}, {e.c, e.a, e.d});
        end
      end
      if (pix_valid) begin
        if (pix_q.size() == 0) chk("spurious_pix_valid", pix_valid, 0);
        else begin
          e = pix_q.pop_front();
          chk("pixel", {cyc, pix_index, pix_data}, {e.c, e.a[9:0], e.d});
        end
      end
      if (done) begin
        if (done_q.size() == 0) chk("spurious_done", done, 0);
        else begin
          dc = done_q.pop_front();
          chk("done_cycle", cyc, dc);
        end
      end
    end
  end
  initial begin
    bit g, hit;
    for (int k = 0; k < 1024; k++) mem[k] = k;
    for (int k = 0; k < N; k++) ref_mem[k] = k;
    #1 reset = 1;
    #2 chk("reset_state", {mem_addr, mem_wdata, mem_we, pix_valid, pix_data, pix_index, done, busy}, 0);
    repeat (2) @(posedge CLOCK_50);
    #1 reset = 0;
    free_at = 0;
    drive(1, 0, 0, 0, 0, g);
    idle_cycles(N + 3);
    drive(0, 0, 1, 406, 1, g);
    drive(0, 0, 1, 784, 32'hffff_ffff, g);
    idle_cycles(2);
    drive(1, 0, 1, 10, 32'hdead_beef, g);
    g = 0;
    for (int i = 0; i < N + 10 && !g; i++) drive(0, 0, 1, 10, 32'hdead_beef, g);
    if (!g) chk("held_write_granted", g, 1);
    idle_cycles(2);
    drive(1, 0, 0, 0, 0, g);
    hit = 0;
    for (int i = 0; i < N + 5 && !hit; i++) begin
      drive(0, 0, 0, 0, 0, g);
      hit = pix_valid && pix_index == 300;
    end
    chk("reached_index_300", hit, 1);
    reset = 1;
    #1 chk("async_reset_outputs", {mem_addr, mem_wdata, mem_we, pix_valid, pix_data, pix_index, done, busy}, 0);
    wr_q.delete(); pix_q.delete(); done_q.delete();
    @(posedge CLOCK_50); #1 reset = 0;
    free_at = 0;
    drive(1, 0, 0, 0, 0, g);
    idle_cycles(N + 3);
    drive(0, 1, 0, 0, 0, g);
    idle_cycles(N + 3);
    for (int i = 0; i < 4000; i++)
      drive($urandom_range(0, 149) == 0, $urandom_range(0, 149) == 0, 1'($urandom),
            16'($urandom_range(0, N + 20)), $urandom, g);
    for (int i = 0; i < 2000 && (wr_q.size() + pix_q.size() + done_q.size()) != 0; i++) idle_cycles(1);
    chk("leftover_expected", wr_q.size() + pix_q.size() + done_q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end
endmodule
